rv_stage_ctrl: RTL and testbench

RV_STAGE_CTRL -- requirements
Module: rv_stage_ctrl

---
 rtl/rv_pkg.sv | 24 ++
 rtl/rv_stage_ctrl_if.sv | 22 ++
 rtl/rv_wb_master.sv | 74 +++++++
 rtl/rv_stage_ctrl.sv | 118 +++++++++++
 tb/tb_rv_stage_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared stage encodings, fault causes and bus request record for rv_stage_ctrl.
package rv_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEMORY  = 3'd4,
    ST_WRITE   = 3'd5,
    ST_FAULT   = 3'd6
  } stage_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ERR     = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/rv_stage_ctrl_if.sv
// Wishbone master/slave bundle between rv_stage_ctrl and the memory system.
interface rv_stage_ctrl_if;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic        o_wb_stb;
  logic        o_wb_cyc;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport master (
    output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
    input  i_wb_dat, i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
    output i_wb_dat, i_wb_ack, i_wb_err
  );
endinterface

// File: rtl/rv_wb_master.sv
// Single-transfer Wishbone handshake: latches a request, holds it until ack/err.
// Optional RV_BUS_TIMEOUT_EN adds a wait counter that aborts after TIMEOUT_CYCLES.
module rv_wb_master
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req,
  input  wb_req_t         i_req_bits,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic            o_timeout,
  output logic [31:0]     o_rdata,
  rv_stage_ctrl_if.master wb
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("rv_wb_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic    cyc_q;
  wb_req_t req_q;
  logic    ack, err;

  // Responses only count while a cycle is open; stray ack/err are dropped here.
  assign ack = cyc_q & wb.i_wb_ack;
  assign err = cyc_q & wb.i_wb_err;

  assign o_busy  = cyc_q;
  assign o_done  = ack & ~err;
  assign o_err   = err;
  assign o_rdata = wb.i_wb_dat;

  assign wb.o_wb_cyc = cyc_q;
  assign wb.o_wb_stb = cyc_q;
  assign wb.o_wb_we  = req_q.we;
  assign wb.o_wb_adr = req_q.adr;
  assign wb.o_wb_dat = req_q.dat;
  assign wb.o_wb_sel = req_q.sel;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cyc_q <= 1'b0;
      req_q <= '0;
    end else if (!cyc_q) begin
      if (i_req) begin
        cyc_q <= 1'b1;
        req_q <= i_req_bits;
      end
    end else if (ack || err || o_timeout) begin
      cyc_q    <= 1'b0;
      req_q.we <= 1'b0;
    end
  end

`ifdef RV_BUS_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !cyc_q) wait_cnt <= '0;
    else if (!ack && !err)    wait_cnt <= wait_cnt + 16'd1;
  end

  // Fires in the last unanswered cycle so FAULT lands TIMEOUT_CYCLES after stb rose.
  assign o_timeout = cyc_q & ~wb.i_wb_ack & ~wb.i_wb_err
                   & (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/rv_stage_ctrl.sv
// Multi-cycle stage sequencer FETCH..WRITE with one Wishbone master shared by fetch and memory.
// Optional RV_BUS_TIMEOUT_EN enables the bus wait timeout (fault cause 2).
module rv_stage_ctrl
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [31:2]     i_fetch_pc,
  input  logic            i_mem_rd,
  input  logic            i_mem_wr,
  input  logic [31:2]     i_mem_addr,
  input  logic [31:0]     i_mem_wdata,
  input  logic [3:0]      i_mem_sel,
  output logic [2:0]      o_stage,
  output logic            o_fetch_stall,
  output logic            o_pre_stall,
  output logic            o_decode_flush,
  output logic [31:0]     o_instr,
  output logic            o_instr_valid,
  output logic [31:0]     o_rdata,
  output logic            o_rdata_valid,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause,
  rv_stage_ctrl_if.master wb
);

  stage_e      state;
  logic        first_fetch;
  logic        bus_req;
  wb_req_t     req_bits;
  logic        m_busy, m_done, m_err, m_tmo;
  logic [31:0] m_rdata;

  // The first fetch after reset goes to RESET_ADDR; later fetches follow the PC.
  always_comb begin
    bus_req  = 1'b0;
    req_bits = '0;
    if (state == ST_FETCH) begin
      bus_req      = 1'b1;
      req_bits.adr = first_fetch ? RESET_ADDR : {i_fetch_pc, 2'b00};
      req_bits.sel = 4'hF;
    end else if (state == ST_MEMORY) begin
      bus_req      = i_mem_rd | i_mem_wr;
      req_bits.we  = i_mem_wr;
      req_bits.adr = {i_mem_addr, 2'b00};
      req_bits.dat = i_mem_wdata;
      req_bits.sel = i_mem_sel;
    end
  end

  rv_wb_master #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wb (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_req      (bus_req),
    .i_req_bits (req_bits),
    .o_busy     (m_busy),
    .o_done     (m_done),
    .o_err      (m_err),
    .o_timeout  (m_tmo),
    .o_rdata    (m_rdata),
    .wb         (wb)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= ST_FETCH;
      first_fetch   <= 1'b1;
      o_instr       <= '0;
      o_instr_valid <= 1'b0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_fault       <= 1'b0;
      o_fault_cause <= CAUSE_NONE;
    end else begin
      o_instr_valid <= 1'b0;
      o_rdata_valid <= 1'b0;
      if (m_err || m_tmo) begin
        state         <= ST_FAULT;
        o_fault       <= 1'b1;
        o_fault_cause <= m_err ? CAUSE_ERR : CAUSE_TIMEOUT;
      end else begin
        case (state)
          ST_FETCH: if (m_done) begin
            o_instr       <= m_rdata;
            o_instr_valid <= 1'b1;
            first_fetch   <= 1'b0;
            state         <= ST_DECODE;
          end
          ST_DECODE:  state <= ST_EXECUTE;
          ST_EXECUTE: state <= ST_MEMORY;
          ST_MEMORY: begin
            if (m_done) begin
              if (!wb.o_wb_we) begin
                o_rdata       <= m_rdata;
                o_rdata_valid <= 1'b1;
              end
              state <= ST_WRITE;
            end else if (!m_busy && !(i_mem_rd || i_mem_wr)) begin
              state <= ST_WRITE;
            end
          end
          ST_WRITE: state <= ST_FETCH;
          ST_FAULT: ;
          default:  ;
        endcase
      end
    end
  end

  assign o_stage        = state;
  assign o_fetch_stall  = (state != ST_FETCH);
  assign o_pre_stall    = (state != ST_WRITE);
  assign o_decode_flush = !((state == ST_FETCH) && m_done);

endmodule

// File: tb/tb_rv_stage_ctrl.sv
// Self-checking bench for rv_stage_ctrl: vector table, randomized transactions, directed corners.
module tb_rv_stage_ctrl;
  import rv_pkg::*;

  localparam logic [31:0] RST_A = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:2] i_fetch_pc = '0;
  logic        i_mem_rd = 1'b0, i_mem_wr = 1'b0;
  logic [31:2] i_mem_addr = '0;
  logic [31:0] i_mem_wdata = '0;
  logic [3:0]  i_mem_sel = '0;
  logic [2:0]  o_stage;
  logic        o_fetch_stall, o_pre_stall, o_decode_flush;
  logic [31:0] o_instr, o_rdata;
  logic        o_instr_valid, o_rdata_valid, o_fault;
  logic [1:0]  o_fault_cause;

  rv_stage_ctrl_if wb();

  rv_stage_ctrl #(.RESET_ADDR(RST_A), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_fetch_pc(i_fetch_pc),
    .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_sel(i_mem_sel), .o_stage(o_stage),
    .o_fetch_stall(o_fetch_stall), .o_pre_stall(o_pre_stall),
    .o_decode_flush(o_decode_flush), .o_instr(o_instr), .o_instr_valid(o_instr_valid),
    .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_fault(o_fault),
    .o_fault_cause(o_fault_cause), .wb(wb)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:2] pc;
    logic        rd, wr;
    logic [31:2] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          fdly;
    logic [31:0] fdata;
    int          mdly;
    logic [31:0] mdata;
    logic [31:0] exp_fadr;
    logic        exp_we, exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  int          errors = 0, checks = 0;
  logic [31:0] model_rdata = '0, model_instr = '0;
  bit          model_first = 1'b1;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic chkst(input string name, input stage_e exp);
    chk({name, " stage"}, {29'd0, o_stage}, {29'd0, exp});
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0;
    repeat (2) @(negedge i_clk);
    chkst("rst", ST_FETCH);
    chk1("rst cyc", wb.o_wb_cyc, 1'b0);
    chk1("rst stb", wb.o_wb_stb, 1'b0);
    chk("rst instr", o_instr, 32'h0);
    chk("rst rdata", o_rdata, 32'h0);
    chk1("rst ivalid", o_instr_valid, 1'b0);
    chk1("rst rvalid", o_rdata_valid, 1'b0);
    chk1("rst fault", o_fault, 1'b0);
    chk("rst cause", {30'd0, o_fault_cause}, 32'd0);
    i_reset_n = 1'b1;
    model_first = 1'b1; model_rdata = '0; model_instr = '0;
  endtask

  // Acts as slave for one transfer: waits for cyc, checks request, acks after dly extra cycles.
  task automatic bus_slave(input string tag, input logic [31:0] adr, input logic we,
                           input logic [3:0] sel, input logic [31:0] dat, input int dly,
                           input logic [31:0] rsp, input bit is_fetch);
    int n = 0;
    bit held = 1'b1;
    while (!wb.o_wb_cyc && n < 50) begin @(negedge i_clk); n++; end
    chk1({tag, " cyc seen"}, wb.o_wb_cyc, 1'b1);
    if (!wb.o_wb_cyc) return;
    chk({tag, " adr"}, wb.o_wb_adr, adr);
    chk1({tag, " we"}, wb.o_wb_we, we);
    chk({tag, " sel"}, {28'd0, wb.o_wb_sel}, {28'd0, sel});
    if (we) chk({tag, " dat"}, wb.o_wb_dat, dat);
    repeat (dly) begin
      @(negedge i_clk);
      if (!(wb.o_wb_cyc && wb.o_wb_stb)) held = 1'b0;
    end
    chk1({tag, " stb held"}, held, 1'b1);
    wb.i_wb_ack = 1'b1; wb.i_wb_dat = rsp;
    #1;
    if (is_fetch) chk1({tag, " flush"}, o_decode_flush, 1'b0);
    @(negedge i_clk);
    wb.i_wb_ack = 1'b0; wb.i_wb_dat = 32'h5A5A_0F0F;
    chk1({tag, " cyc drop"}, wb.o_wb_cyc, 1'b0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    i_fetch_pc = v.pc; i_mem_rd = v.rd; i_mem_wr = v.wr;
    i_mem_addr = v.addr; i_mem_sel = v.sel; i_mem_wdata = v.wdata;
    chkst({tag, " F"}, ST_FETCH);
    chk1({tag, " fstall"}, o_fetch_stall, 1'b0);
    bus_slave({tag, " F"}, v.exp_fadr, 1'b0, 4'hF, 32'h0, v.fdly, v.fdata, 1'b1);
    chkst({tag, " D"}, ST_DECODE);
    chk1({tag, " ivalid"}, o_instr_valid, 1'b1);
    chk({tag, " instr"}, o_instr, v.fdata);
    // ack/err with no open cycle must be ignored
    wb.i_wb_ack = 1'b1; wb.i_wb_err = 1'b1;
    @(negedge i_clk);
    wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0;
    chkst({tag, " E"}, ST_EXECUTE);
    chk1({tag, " stray fault"}, o_fault, 1'b0);
    chk1({tag, " ivalid off"}, o_instr_valid, 1'b0);
    @(negedge i_clk);
    chkst({tag, " M"}, ST_MEMORY);
    if (v.rd || v.wr)
      bus_slave({tag, " M"}, {v.addr, 2'b00}, v.exp_we, v.sel, v.wdata, v.mdly, v.mdata, 1'b0);
    else begin
      chk1({tag, " M idle"}, wb.o_wb_cyc, 1'b0);
      @(negedge i_clk);
    end
    chkst({tag, " W"}, ST_WRITE);
    chk1({tag, " prestall"}, o_pre_stall, 1'b0);
    chk1({tag, " rvalid"}, o_rdata_valid, v.exp_rvalid);
    chk({tag, " rdata"}, o_rdata, v.exp_rdata);
    @(negedge i_clk);
    chkst({tag, " F2"}, ST_FETCH);
    chk1({tag, " rvalid off"}, o_rdata_valid, 1'b0);
    if (v.rd && !v.wr) model_rdata = v.mdata;
    model_instr = v.fdata;
    model_first = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   n;
    wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0; wb.i_wb_dat = '0;
    //           pc        rd    wr    addr           sel      wdata         fd fdata         md mdata         fadr          we    rv    rdata
    tbl[0] = '{30'h0,     1'b0, 1'b0, 30'h0,         4'hF,    32'h0,        2, 32'h0000_0013, 0, 32'h0,        32'h0000_0000, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{30'h1,     1'b1, 1'b0, 30'h400,       4'hF,    32'h0,        1, 32'h0000_0093, 1, 32'hDEAD_BEEF, 32'h0000_0004, 1'b0, 1'b1, 32'hDEAD_BEEF};
    tbl[2] = '{30'h2,     1'b0, 1'b1, 30'h10,        4'b0011, 32'h0000_1234, 0, 32'h0000_0023, 2, 32'hFFFF_FFFF, 32'h0000_0008, 1'b1, 1'b0, 32'hDEAD_BEEF};
    tbl[3] = '{30'h3,     1'b1, 1'b1, 30'h3FFF_FFFF, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0000_0033, 0, 32'h1111_1111, 32'h0000_000C, 1'b1, 1'b0, 32'hDEAD_BEEF};
    tbl[4] = '{30'h3FFF_FFFF, 1'b1, 1'b0, 30'h0,     4'b0001, 32'h0,        0, 32'h0000_0003, 0, 32'h0000_0080, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0080};
    tbl[5] = '{30'h100,   1'b0, 1'b0, 30'h5,         4'hF,    32'h0,        5, 32'h0000_006F, 0, 32'h0,        32'h0000_0400, 1'b0, 1'b0, 32'h0000_0080};

    @(negedge i_clk);
    do_reset();
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // randomized transactions against the per-instruction model
    for (int i = 0; i < 40; i++) begin
      v.pc    = 30'($urandom);
      v.rd    = 1'($urandom);
      v.wr    = ($urandom_range(0, 3) == 0);
      v.addr  = 30'($urandom);
      v.sel   = 4'($urandom);
      v.wdata = $urandom;
      v.fdly  = int'($urandom_range(0, 3));
      v.fdata = $urandom;
      v.mdly  = int'($urandom_range(0, 3));
      v.mdata = $urandom;
      v.exp_fadr   = model_first ? RST_A : {v.pc, 2'b00};
      v.exp_we     = v.wr;
      v.exp_rvalid = v.rd && !v.wr;
      v.exp_rdata  = v.exp_rvalid ? v.mdata : model_rdata;
      run_vec($sformatf("rnd%0d", i), v);
    end

    // err together with ack during fetch
    n = 0;
    while (!wb.o_wb_cyc && n < 50) begin @(negedge i_clk); n++; end
    chk1("errfetch cyc seen", wb.o_wb_cyc, 1'b1);
    wb.i_wb_ack = 1'b1; wb.i_wb_err = 1'b1; wb.i_wb_dat = 32'hBAD0_BAD0;
    @(negedge i_clk);
    wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0;
    chkst("errfetch", ST_FAULT);
    chk1("errfetch fault", o_fault, 1'b1);
    chk("errfetch cause", {30'd0, o_fault_cause}, 32'd1);
    chk("errfetch instr", o_instr, model_instr);
    chk1("errfetch ivalid", o_instr_valid, 1'b0);
    repeat (3) @(negedge i_clk);
    chk1("errfetch cyc held", wb.o_wb_cyc, 1'b0);
    chk1("errfetch we", wb.o_wb_we, 1'b0);
    chkst("errfetch held", ST_FAULT);
    do_reset();

    // reset during the 2nd wait cycle of a load, ack arrives after reset
    i_fetch_pc = 30'h55; i_mem_rd = 1'b1; i_mem_wr = 1'b0; i_mem_addr = 30'h400; i_mem_sel = 4'hF;
    bus_slave("rml F", RST_A, 1'b0, 4'hF, 32'h0, 0, 32'h0000_0013, 1'b1);
    repeat (2) @(negedge i_clk);
    chkst("rml M", ST_MEMORY);
    n = 0;
    while (!wb.o_wb_cyc && n < 50) begin @(negedge i_clk); n++; end
    chk1("rml cyc seen", wb.o_wb_cyc, 1'b1);
    @(negedge i_clk);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    wb.i_wb_ack = 1'b1; wb.i_wb_dat = 32'hCAFE_F00D;
    chkst("rml rst", ST_FETCH);
    chk1("rml cyc abandoned", wb.o_wb_cyc, 1'b0);
    @(negedge i_clk);
    wb.i_wb_ack = 1'b0;
    chk1("rml rvalid", o_rdata_valid, 1'b0);
    chk("rml rdata", o_rdata, 32'h0);
    chkst("rml refetch", ST_FETCH);
    chk1("rml refetch cyc", wb.o_wb_cyc, 1'b1);
    chk("rml refetch adr", wb.o_wb_adr, RST_A);
    do_reset();

    // unanswered fetch: timeout when enabled, unbounded wait otherwise
    n = 0;
    while (!wb.o_wb_cyc && n < 50) begin @(negedge i_clk); n++; end
    chk1("tmo cyc seen", wb.o_wb_cyc, 1'b1);
`ifdef RV_BUS_TIMEOUT_EN
    repeat (3) @(negedge i_clk);
    chkst("tmo cycle4", ST_FETCH);
    @(negedge i_clk);
    chkst("tmo cycle5", ST_FAULT);
    chk("tmo cause", {30'd0, o_fault_cause}, 32'd2);
    chk1("tmo cyc", wb.o_wb_cyc, 1'b0);
`else
    n = 0;
    repeat (1000) begin
      @(negedge i_clk);
      if (!wb.o_wb_stb) n++;
    end
    chk("wait stb drops", n, 0);
    chk1("wait fault", o_fault, 1'b0);
    chkst("wait", ST_FETCH);
    bus_slave("wait F", RST_A, 1'b0, 4'hF, 32'h0, 0, 32'h0000_0013, 1'b1);
    chkst("wait done", ST_DECODE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
